neuron_scheduler: RTL and testbench
===================================

# neuron_scheduler

Time-step sequencer that drives the pipelined LIF `integrator` as its initiator. On each `start` it sweeps every neuron once:
- reads the stored membrane potential and the external synaptic stimulus, issues one integrator operation per cycle;
- writes the returned potential back into its membrane memory;
- queues the ids of spiking neurons into an event FIFO with valid/ready output.

It sits between the synaptic accumulator (stimulus source) and the spike-routing logic.

## Interface
- `WIDTH`, 25, membrane/stimulus/threshold width (matches integrator)
- `N_NEURONS`, 64, neurons per time step
- `ADDR_W`, 6, neuron id width, ≥ clog2(`N_NEURONS`)
- `LATENCY`, 4, integrator en→valid latency in cycles
- `FIFO_DEPTH`, 8, spike event FIFO entries
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  begin one time step; sampled only in IDLE
- `decay`  in  14  Q2.12 decay; latched at start
- `threshold`  in  `WIDTH`  firing threshold; latched at start
- `detection_en`  in  1  spike detection enable; latched at start
- `stim_addr`  out  `ADDR_W`  stimulus read address; data returns next cycle
- `stim_data`  in  `WIDTH`  signed stimulus for `stim_addr` of the previous cycle
- `int_en`, `int_detection`  out  1  integrator operation strobe / detection flag
- `int_output_old`, `int_stimolo`, `int_threshold`  out  `WIDTH`  integrator operands
- `int_decay`  out  14  integrator decay
- `int_valid`, `int_spike`  in  1  integrator result strobe / spike flag
- `int_output_new`  in  `WIDTH`  updated potential
- `evt_valid`  out  1  spike event available
- `evt_ready`  in  1  consumer accepts event
- `evt_id`  out  `ADDR_W`  spiking neuron id
- `busy`  out  1  high outside IDLE
- `done`  out  1  one-cycle pulse at end of time step
- `spike_cnt`  out  `ADDR_W+1`  spikes in last time step (see Configuration)

## Operation
- Membrane memory: `N_NEURONS` × `WIDTH`, synchronous read, 1-cycle latency. Written only by INIT and writeback.
- FSM:
  - INIT: entered on reset. Writes 0 to address 0..`N_NEURONS`-1, one per cycle, then goes to IDLE.
  - IDLE: on `start`, latches `decay`, `threshold` and `detection_en`, clears the issue counter, then goes to RUN.
  - RUN: issues address `k` to the memory and to `stim_addr` when a credit is available. After address `N_NEURONS`-1 is issued, goes to DRAIN.
  - DRAIN: waits until in-flight = 0, then goes to DONE.
  - DONE: asserts `done` for one cycle, then goes to IDLE.
- `start` outside IDLE is ignored.
- Issue stage: one cycle after an issue, drive `int_en`=1 with:
  - `int_output_old` = memory data and `int_stimolo` = `stim_data`;
  - the latched decay, threshold and detection values.
- A tag shift register (depth 1+`LATENCY`) carries the neuron id alongside each operation.
- On `int_valid`: write `int_output_new` to `mem[tag]`. If `int_spike`=1, also push `tag` into the FIFO.
- Credit rule: issue only if fifo_count + in-flight < `FIFO_DEPTH`. The integrator cannot stall, so no event is ever dropped.
- In-flight count is operations between issue and `int_valid`: +1 on issue, -1 on `int_valid`.
- FIFO: standard valid/ready. `evt_id` is held stable while `evt_valid` && !`evt_ready`. Simultaneous push and pop keep the count unchanged. Events emerge in ascending id order.
- FIFO contents persist across DONE/IDLE until consumed.

## Timing
- Reset values:
  - `busy`=1 (INIT);
  - `done`, `evt_valid`, `int_en`, `int_detection`=0;
  - `stim_addr`, `evt_id`, `spike_cnt`, operands=0;
  - FIFO empty, in-flight=0.
- Unthrottled time step (start seen at cycle 0):
  - RUN at cycles 1..`N_NEURONS`;
  - `int_en` at cycles 2..`N_NEURONS`+1;
  - `int_valid` at cycles 6..`N_NEURONS`+5;
  - `done` at cycle `N_NEURONS`+6.
- Event for neuron k: `evt_valid` visible the cycle after its `int_valid`.
- `rst` at any time: all in-flight results and FIFO contents are discarded; INIT restarts. The integrator shares `rst`.

## Configuration
- `NEURON_SCHED_SPIKE_CNT_EN` defined: a counter increments on each pushed spike. It clears at the IDLE→RUN transition and is copied to `spike_cnt` in the DONE cycle.
- Not defined: no counter logic; `spike_cnt` is tied to 0.

## Test plan
- Reset, then release: `busy`=1 for exactly 64 cycles (INIT), then 0. A time step with stim 0 and decay 4096 reads back all-zero membranes.
- Accumulate: stim=10 for all neurons, threshold=100, decay=4096, detection_en=1, `evt_ready`=1, repeated steps:
  - no events in steps 1–9;
  - step 10 yields 64 events, ids 0..63 in order;
  - membranes read back as 0 afterwards.
- Latency: single start with `evt_ready`=1 → first `int_en` at cycle 2, first `int_valid` at cycle 6, `done` at cycle 70.
- Backpressure: all neurons spike, `evt_ready`=0:
  - issue stalls with fifo_count + in-flight = 8;
  - exactly 8 events are buffered;
  - raising `evt_ready` releases all 64 ids in order, with no duplicates or losses;
  - `done` follows the last writeback.
- Ignore/disable: `start` pulsed during RUN has no effect. detection_en=0 with threshold exceeded → zero events and membranes keep accumulating; `spike_cnt`=0 when the macro is enabled.
- `rst` mid-RUN (cycle 30): next cycle `evt_valid`=0 and `int_en`=0; INIT runs 64 cycles; a following step starts from zero membranes.

Source files
------------

// File: rtl/neuron_scheduler_if.sv
//============================================================================
// Module      : neuron_scheduler_if
// Description : Bundle of the control, stimulus, integrator and spike-event
//               signals of the neuron_scheduler time-step sequencer.
//               master = scheduler side, slave = environment side.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

interface neuron_scheduler_if #(
    parameter int WIDTH  = 25,
    parameter int ADDR_W = 6
);
    // Time-step control
    logic              start;
    logic [13:0]       decay;
    logic [WIDTH-1:0]  threshold;
    logic              detection_en;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   spike_cnt;

    // Stimulus source
    logic [ADDR_W-1:0] stim_addr;
    logic [WIDTH-1:0]  stim_data;

    // Integrator operation / result
    logic              int_en;
    logic              int_detection;
    logic [WIDTH-1:0]  int_output_old;
    logic [WIDTH-1:0]  int_stimolo;
    logic [WIDTH-1:0]  int_threshold;
    logic [13:0]       int_decay;
    logic              int_valid;
    logic              int_spike;
    logic [WIDTH-1:0]  int_output_new;

    // Spike event stream
    logic              evt_valid;
    logic              evt_ready;
    logic [ADDR_W-1:0] evt_id;

    modport master (
        input  start, decay, threshold, detection_en, stim_data,
               int_valid, int_spike, int_output_new, evt_ready,
        output busy, done, spike_cnt, stim_addr,
               int_en, int_detection, int_output_old, int_stimolo,
               int_threshold, int_decay, evt_valid, evt_id
    );

    modport slave (
        output start, decay, threshold, detection_en, stim_data,
               int_valid, int_spike, int_output_new, evt_ready,
        input  busy, done, spike_cnt, stim_addr,
               int_en, int_detection, int_output_old, int_stimolo,
               int_threshold, int_decay, evt_valid, evt_id
    );
endinterface

`default_nettype wire

// File: rtl/neuron_scheduler.sv
//============================================================================
// Module      : neuron_scheduler
// Description : Time-step sequencer driving the pipelined LIF integrator.
//               Sweeps all neurons once per start, writes updated membrane
//               potentials back and queues spiking neuron ids into an event
//               FIFO. Issue is credit-limited so no event is ever dropped.
//               Optional feature macro: NEURON_SCHED_SPIKE_CNT_EN
//               (per-time-step spike counter on spike_cnt).
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module neuron_scheduler #(
    parameter int WIDTH      = 25,
    parameter int N_NEURONS  = 64,
    parameter int ADDR_W     = 6,
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    neuron_scheduler_if.master  bus
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int FPTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_NEURONS - 1);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;      // INIT write address / RUN issue index
    logic              issue, init_we, latch;

    logic [13:0]       decay_q;
    logic [WIDTH-1:0]  thr_q;
    logic              det_q;
    logic              en_q;
    logic [WIDTH-1:0]  rdata_q;
    logic [ADDR_W-1:0] tag_q [LATENCY+1];
    logic [CNT_W-1:0]  inflight_q, inflight_d;

    logic [WIDTH-1:0]  mem_q [N_NEURONS];

    logic [ADDR_W-1:0] fifo_q [FIFO_DEPTH];
    logic [FPTR_W-1:0] rptr_q, wptr_q;
    logic [CNT_W-1:0]  fifo_cnt_q;
    logic              push, pop;
    logic [CNT_W:0]    occupancy;
    logic              credit_ok;

    function automatic logic [FPTR_W-1:0] ptr_inc(input logic [FPTR_W-1:0] p);
        return (p == FPTR_W'(FIFO_DEPTH - 1)) ? '0 : p + FPTR_W'(1);
    endfunction

    // Tag at the last stage belongs to the result arriving on int_valid
    assign push       = bus.int_valid && bus.int_spike;
    assign pop        = (fifo_cnt_q != '0) && bus.evt_ready;
    // Every issued op may end up as a FIFO entry, so reserve room up front
    assign occupancy  = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
    assign credit_ok  = occupancy < (CNT_W+1)'(FIFO_DEPTH);
    assign inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(bus.int_valid);

    // Next-state and strobe decode
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        issue   = 1'b0;
        init_we = 1'b0;
        latch   = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_we = 1'b1;
                addr_d  = addr_q + ADDR_W'(1);
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (bus.start) begin
                    latch   = 1'b1;
                    addr_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (credit_ok) begin
                    issue  = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                    if (addr_q == LAST_ADDR) begin
                        addr_d  = '0;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Leave as the final result lands so done follows it directly
                if (inflight_d == '0) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_INIT;
        endcase
    end

    // FSM, latched parameters, issue stage and tag pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            addr_q     <= '0;
            decay_q    <= '0;
            thr_q      <= '0;
            det_q      <= 1'b0;
            en_q       <= 1'b0;
            rdata_q    <= '0;
            inflight_q <= '0;
            for (int i = 0; i <= LATENCY; i++) tag_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            en_q       <= issue;
            inflight_q <= inflight_d;
            if (latch) begin
                decay_q <= bus.decay;
                thr_q   <= bus.threshold;
                det_q   <= bus.detection_en;
            end
            if (issue) rdata_q <= mem_q[addr_q];
            tag_q[0] <= addr_q;
            for (int i = 1; i <= LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    // Membrane memory: INIT clear or result writeback
    always_ff @(posedge clk) begin
        if (init_we)            mem_q[addr_q]         <= '0;
        else if (bus.int_valid) mem_q[tag_q[LATENCY]] <= bus.int_output_new;
    end

    // Spike event FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q     <= '0;
            wptr_q     <= '0;
            fifo_cnt_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            if (push) begin
                fifo_q[wptr_q] <= tag_q[LATENCY];
                wptr_q         <= ptr_inc(wptr_q);
            end
            if (pop) rptr_q <= ptr_inc(rptr_q);
            fifo_cnt_q <= fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

`ifdef NEURON_SCHED_SPIKE_CNT_EN
    logic [ADDR_W:0] spk_acc_q, spike_cnt_q;

    // Count pushed spikes in the current step, publish in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            spk_acc_q   <= '0;
            spike_cnt_q <= '0;
        end else begin
            if (latch)     spk_acc_q <= '0;
            else if (push) spk_acc_q <= spk_acc_q + (ADDR_W+1)'(1);
            if (state_q == ST_DONE) spike_cnt_q <= spk_acc_q;
        end
    end
    assign bus.spike_cnt = spike_cnt_q;
`else
    assign bus.spike_cnt = '0;
`endif

    assign bus.stim_addr      = addr_q;
    assign bus.int_en         = en_q;
    assign bus.int_output_old = rdata_q;
    assign bus.int_stimolo    = en_q ? bus.stim_data : '0;
    assign bus.int_decay      = decay_q;
    assign bus.int_threshold  = thr_q;
    assign bus.int_detection  = det_q;
    assign bus.evt_valid      = (fifo_cnt_q != '0);
    assign bus.evt_id         = fifo_q[rptr_q];
    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.done           = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_neuron_scheduler.sv
//============================================================================
// Module      : tb_neuron_scheduler
// Description : Directed self-checking bench for neuron_scheduler with a
//               behavioural 4-cycle LIF integrator and stimulus source.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_neuron_scheduler;
    localparam int WIDTH  = 25;
    localparam int N      = 64;
    localparam int ADDR_W = 6;
    localparam int LAT    = 4;
    localparam int FD     = 8;
`ifdef NEURON_SCHED_SPIKE_CNT_EN
    localparam int CNT_STEP10 = 64;
`else
    localparam int CNT_STEP10 = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    neuron_scheduler_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus();

    neuron_scheduler #(
        .WIDTH(WIDTH), .N_NEURONS(N), .ADDR_W(ADDR_W),
        .LATENCY(LAT), .FIFO_DEPTH(FD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Stimulus source: data for the address of the previous cycle
    logic signed [WIDTH-1:0] stim_val;
    always @(posedge clk) bus.stim_data <= stim_val;

    // Behavioural LIF integrator: v = old*decay/4096 + stim, fire and reset on v >= thr
    logic signed [39:0]      prod;
    logic signed [WIDTH-1:0] v_new;
    logic                    sp_new;
    always_comb begin
        prod   = 40'($signed(bus.int_output_old)) * 40'($signed({1'b0, bus.int_decay}));
        v_new  = WIDTH'(prod >>> 12) + $signed(bus.int_stimolo);
        sp_new = bus.int_detection && (v_new >= $signed(bus.int_threshold));
    end

    logic [LAT-1:0]   pv_q, ps_q;
    logic [WIDTH-1:0] pn_q [LAT];
    always @(posedge clk) begin
        if (rst) begin
            pv_q <= '0;
            ps_q <= '0;
        end else begin
            pv_q    <= {pv_q[LAT-2:0], bus.int_en};
            ps_q    <= {ps_q[LAT-2:0], sp_new};
            pn_q[0] <= sp_new ? '0 : v_new;
            for (int i = 1; i < LAT; i++) pn_q[i] <= pn_q[i-1];
        end
    end
    assign bus.int_valid      = pv_q[LAT-1];
    assign bus.int_spike      = ps_q[LAT-1];
    assign bus.int_output_new = pn_q[LAT-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Count consecutive busy cycles starting at the current negedge
    task automatic init_count(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    int cyc, n_en, first_en, first_val, last_val, done_cyc, n_done, old_bad, n_evt, order_bad;

    // One time step from IDLE; start driven at the current negedge (cycle 0)
    task automatic run_step(input logic [13:0] dcy, input logic [WIDTH-1:0] thr,
                            input logic det, input logic signed [WIDTH-1:0] stim,
                            input logic [WIDTH-1:0] exp_old, input int exp_evt,
                            input int pulse_at, input int release_at, input string tag);
        stim_val         = stim;
        bus.decay        = dcy;
        bus.threshold    = thr;
        bus.detection_en = det;
        bus.evt_ready    = (release_at == 0);
        n_en = 0; first_en = -1; first_val = -1; last_val = -1;
        done_cyc = -1; n_done = 0; old_bad = 0; n_evt = 0; order_bad = 0;
        bus.start = 1'b1;
        cyc = 0;
        while (cyc < 600) begin
            @(negedge clk);
            cyc++;
            bus.start = (cyc == pulse_at);
            if (release_at > 0 && cyc == release_at) bus.evt_ready = 1'b1;
            if (release_at > 0 && cyc == release_at - 1) begin
                check({tag, " stalled issues"}, 64'(n_en), 64'(FD));
                check({tag, " fifo count"}, 64'(dut.fifo_cnt_q), 64'(FD));
                check({tag, " in-flight"}, 64'(dut.inflight_q), 64'd0);
                check({tag, " held evt_id"}, 64'(bus.evt_id), 64'd0);
            end
            if (bus.int_en) begin
                n_en++;
                if (first_en < 0) first_en = cyc;
                if (bus.int_output_old !== exp_old) old_bad++;
            end
            if (bus.int_valid) begin
                if (first_val < 0) first_val = cyc;
                last_val = cyc;
            end
            if (bus.evt_valid && bus.evt_ready) begin
                if (bus.evt_id !== ADDR_W'(n_evt)) order_bad++;
                n_evt++;
            end
            if (bus.done) begin
                done_cyc = cyc;
                n_done++;
            end
            if (done_cyc > 0 && !bus.evt_valid) break;
        end
        @(negedge clk);
        check({tag, " ops issued"}, 64'(n_en), 64'(N));
        check({tag, " membrane readback"}, 64'(old_bad), 64'd0);
        check({tag, " events"}, 64'(n_evt), 64'(exp_evt));
        check({tag, " event order"}, 64'(order_bad), 64'd0);
        check({tag, " first int_en"}, 64'(first_en), 64'd2);
        check({tag, " first int_valid"}, 64'(first_val), 64'd6);
        check({tag, " done pulses"}, 64'(n_done), 64'd1);
        if (release_at == 0) check({tag, " done cycle"}, 64'(done_cyc), 64'd70);
        else                 check({tag, " done after writeback"}, 64'(done_cyc), 64'(last_val + 1));
        check({tag, " idle after done"}, 64'(bus.busy), 64'd0);
    endtask

    int n;

    initial begin
        bus.start = 1'b0; bus.decay = '0; bus.threshold = '0;
        bus.detection_en = 1'b0; bus.evt_ready = 1'b1; stim_val = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst busy", 64'(bus.busy), 64'd1);
        check("rst done", 64'(bus.done), 64'd0);
        check("rst evt_valid", 64'(bus.evt_valid), 64'd0);
        check("rst int_en", 64'(bus.int_en), 64'd0);
        check("rst int_detection", 64'(bus.int_detection), 64'd0);
        check("rst stim_addr", 64'(bus.stim_addr), 64'd0);
        check("rst evt_id", 64'(bus.evt_id), 64'd0);
        check("rst spike_cnt", 64'(bus.spike_cnt), 64'd0);
        check("rst int_output_old", 64'(bus.int_output_old), 64'd0);
        check("rst int_threshold", 64'(bus.int_threshold), 64'd0);

        rst = 1'b0;
        init_count(n);
        check("init busy cycles", 64'(n), 64'd64);

        // Zeroed membranes, latency
        run_step(14'd4096, 25'd100, 1'b1, 25'sd0, 25'd0, 0, 0, 0, "zero");

        // Accumulate 10 per step; threshold crossed on step 10
        for (int s = 1; s <= 9; s++)
            run_step(14'd4096, 25'd100, 1'b1, 25'sd10, 25'(10 * (s - 1)), 0, 0, 0, $sformatf("acc%0d", s));
        run_step(14'd4096, 25'd100, 1'b1, 25'sd10, 25'd90, 64, 0, 0, "acc10");
        check("spike_cnt step10", 64'(bus.spike_cnt), 64'(CNT_STEP10));
        run_step(14'd4096, 25'd100, 1'b1, 25'sd0, 25'd0, 0, 0, 0, "post-fire");

        // Backpressure: every neuron fires, consumer stalled until cycle 40
        run_step(14'd4096, 25'd100, 1'b1, 25'sd200, 25'd0, 64, 0, 40, "bp");

        // start during RUN ignored
        run_step(14'd4096, 25'd100, 1'b1, 25'sd0, 25'd0, 0, 10, 0, "ignore");
        repeat (3) @(negedge clk);
        check("no restart busy", 64'(bus.busy), 64'd0);

        // Detection disabled: no events, membranes keep accumulating
        run_step(14'd4096, 25'd100, 1'b0, 25'sd200, 25'd0, 0, 0, 0, "nodet1");
        run_step(14'd4096, 25'd100, 1'b0, 25'sd200, 25'd200, 0, 0, 0, "nodet2");
        check("spike_cnt nodet", 64'(bus.spike_cnt), 64'd0);

        // Reset in the middle of RUN
        stim_val = 25'sd5; bus.decay = 14'd4096; bus.threshold = 25'd100;
        bus.detection_en = 1'b1; bus.evt_ready = 1'b1;
        bus.start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        check("pre-rst int_en", 64'(bus.int_en), 64'd1);
        check("pre-rst evt_valid", 64'(bus.evt_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("post-rst int_en", 64'(bus.int_en), 64'd0);
        check("post-rst evt_valid", 64'(bus.evt_valid), 64'd0);
        init_count(n);
        check("re-init busy cycles", 64'(n), 64'd64);
        run_step(14'd4096, 25'd100, 1'b0, 25'sd0, 25'd0, 0, 0, 0, "after-rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
